// File: rtl/stream_in.sv
// stream_in: double-buffered deserialiser packing 8 x 16-bit words (MSB word first) into a 128-bit block + type flag
//   clk, rst (async active-high)
//   vin/tin/din/rdy : input word stream, transfer on vin && rdy
//   vout/tout/dout/ack : held block to the AES core, transfer on vout && ack
//   err : one-cycle pulse on type mismatch inside a block (or idle timeout)
//   Optional: define STREAM_IN_TIMEOUT_EN to abort partial blocks idle for TIMEOUT cycles
module stream_in #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vin,
  input  logic         tin,
  input  logic [15:0]  din,
  output logic         rdy,
  output logic         vout,
  output logic         tout,
  output logic [127:0] dout,
  input  logic         ack,
  output logic         err
);
  logic [2:0]   cnt;
  logic [127:0] asm_data, asm_word;
  logic         asm_type, asm_full, accept, mismatch, complete, free, timeout;
  assign rdy      = !asm_full;
  assign accept   = vin && rdy;
  assign mismatch = accept && cnt != 3'd0 && tin != asm_type;
  assign complete = accept && !mismatch && cnt == 3'd7;
  assign free     = !vout || ack;
  // assembly register with the incoming word dropped into slot cnt
  always_comb begin
    asm_word = asm_data;
    for (int j = 0; j < 8; j++)
      if (cnt == 3'(j)) asm_word[127-16*j -: 16] = din;
  end
`ifdef STREAM_IN_TIMEOUT_EN
  logic [7:0] idle;
  assign timeout = cnt != 3'd0 && !accept && idle == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) idle <= '0;
    else idle <= (cnt == 3'd0 || accept || timeout) ? 8'd0 : idle + 8'd1;
`else
  assign timeout = 1'b0 && (TIMEOUT != 0);
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt      <= '0;
      asm_data <= '0;
      asm_type <= 1'b0;
      asm_full <= 1'b0;
      vout     <= 1'b0;
      tout     <= 1'b0;
      dout     <= '0;
      err      <= 1'b0;
    end else begin
      err <= mismatch || timeout;
      if (accept) begin
        asm_data <= mismatch ? {din, 112'b0} : asm_word;
        if (mismatch || cnt == 3'd0) asm_type <= tin;
        cnt <= mismatch ? 3'd1 : cnt + 3'd1;
        if (complete && !free) asm_full <= 1'b1;
      end else if (timeout) cnt <= '0;
      // a completing block bypasses straight into hold when hold is free this edge
      if (complete && free) begin
        dout <= asm_word;
        tout <= asm_type;
        vout <= 1'b1;
      end else if (asm_full && vout && ack) begin
        dout     <= asm_data;
        tout     <= asm_type;
        vout     <= 1'b1;
        asm_full <= 1'b0;
      end else if (ack) vout <= 1'b0;
    end
endmodule

// File: doc/stream_in.md
Name: stream_in

Overview:
- Deserialiser for the 16-bit word stream produced by the block's output-side serialiser.
- Collects 8 consecutive 16-bit words, MSB word first, into one 128-bit block plus a 1-bit type flag (key/data), and presents the block to the AES core.
- Double-buffered: one assembly register plus one holding register, so input can continue while the core consumes the previous block.
- Sits between the external stream interface and the AES core input.

Parameters:
TIMEOUT, 16, idle cycles allowed inside a partial block before abort; used only when STREAM_IN_TIMEOUT_EN is defined; legal range 2..255.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
vin  input  1  input word valid
tin  input  1  input word type (0 = data, 1 = key)
din  input  16  input word
rdy  output  1  input ready; a word transfers when vin && rdy
vout  output  1  assembled block valid
tout  output  1  type of presented block
dout  output  128  assembled block
ack  input  1  consumer accepts block; transfer when vout && ack
err  output  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (async, rst=1):
  - cnt=0, asm_full=0, hold_full=0.
  - vout=0, tout=0, dout=0, err=0, asm data/type=0.
  - rdy=1 after reset.
- rdy = !asm_full (combinational).
- Word accept (vin && rdy):
  - Word k (cnt=k, 0..7) is written to asm bits [127-16k -: 16].
  - Word 0 lands in [127:112]; word 7 lands in [15:0].
  - cnt increments, wrapping 7 -> 0.
  - The type bit is latched from tin on word 0.
- vin low inside a block: stall. cnt and asm data are held; gaps are allowed.
- Type mismatch:
  - Condition: vin && rdy && cnt != 0 && tin != latched type.
  - err=1 for the next cycle and the partial block is discarded.
  - The offending word becomes word 0 of a new block (stored at [127:112], type latched, cnt=1).
- Block completion: accepting word 7 completes the block.
  - If hold is empty, or hold is being acked in the same cycle, asm moves to hold at that edge, so vout=1 the cycle after word 7. Latency is 1 cycle.
  - Otherwise asm_full=1 and rdy=0 until hold frees.
  - When hold frees (ack && vout), asm moves to hold at the same edge and asm_full clears. Hold is refilled the cycle after ack with no bubble.
- Hold register:
  - dout/tout are registered and stable while vout=1.
  - vout clears on ack unless refilled from asm in the same edge.
  - ack while vout=0 is ignored.
- Simultaneous events:
  - Completion of a new block and ack of the held block in one cycle: the new block goes directly to hold and vout stays 1.
  - A type-mismatch word cannot complete a block, because it restarts at cnt=1.
- Reset mid-block or mid-hold: all partial and held data is lost; no err pulse.
- err is a pulse only, never sticky. Mismatch and timeout in the same cycle give a single pulse.

Optional Feature:
Macro STREAM_IN_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter increments each cycle while cnt != 0 and no word is accepted.
  - The counter clears on any accepted word and whenever cnt == 0.
  - When it reaches TIMEOUT: the partial block is discarded, cnt=0, err pulses 1 cycle, the counter clears.
  - Idle cycles caused by rdy=0 never occur with cnt != 0, because asm_full implies cnt=0.
- Undefined: no counter; partial blocks wait indefinitely; TIMEOUT is ignored.

Test Plan:
- Basic block: after reset, with ack held at 1, send 8 back-to-back words 0x0001..0x0008 with tin=1. Required: vout=1 exactly 1 cycle after word 8, dout=0x0001000200030004000500060007_0008, tout=1, err=0.
- Gaps: same 8 words with vin low for 3 cycles between word 3 and word 4. Required: identical dout; vout rises 1 cycle after the last word.
- Backpressure: ack=0; send block A (0xAAAA x8), then block B (0xBBBB x8). Required:
  - vout=1 with dout=A.
  - rdy=0 after B's 8th word, with vin still high and no words accepted.
  - Raise ack for 1 cycle: the next cycle shows dout=B, vout=1, rdy=1.
- Type mismatch: words 0x1111,0x2222 with tin=0, then 0x3333 with tin=1, then 7 more words 0x4444 with tin=1. Required:
  - err=1 for 1 cycle after 0x3333.
  - The resulting block is 0x3333 followed by 7 x 0x4444, with tout=1.
- Reset mid-operation: assert rst after word 5 of a block. Required:
  - vout=0, dout=0, err=0 immediately, without waiting for a clk edge.
  - A following clean 8-word block assembles correctly starting at [127:112].
- Timeout (STREAM_IN_TIMEOUT_EN, TIMEOUT=16): send 3 words, then idle 16 cycles. Required:
  - err pulses once and cnt returns to 0.
  - The next 8 words form a correct block.
  - With the macro undefined, the same stimulus gives no err, and 5 further words complete the original block.
